dmem_wait_ctrl: RTL and testbench

DMEM_WAIT_CTRL -- requirements
Module: dmem_wait_ctrl

---
 rtl/dmem_wait_ctrl_if.sv | 21 ++
 rtl/dmem_wait_ctrl.sv | 132 +++++++++++++
 tb/tb_dmem_wait_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dmem_wait_ctrl_if.sv
// Data-memory bus between the wait controller (master) and the memory
// responder (slave): request strobe with address/data/byte-select, and ack with read data.
interface dmem_wait_ctrl_if;
    logic        bus_stb;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_stb, bus_we, bus_addr, bus_wdata, bus_sel,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_stb, bus_we, bus_addr, bus_wdata, bus_sel,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/dmem_wait_ctrl.sv
// MEM-stage data-memory wait controller: freezes the pipeline while a bus
// access is outstanding, returns registered load data, and abandons silent accesses.
module dmem_wait_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_be,
    output logic                  data_mem_wait,
    output logic [31:0]           mem_rdata,
    output logic                  bus_err,
    dmem_wait_ctrl_if.master      bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc_s;
    logic        wait_s;

    // Next-state, bus register and freeze-request logic.
    always_comb begin
        state_d   = state_q;
        stb_d     = stb_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        sel_d     = sel_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        cnt_inc_s = cnt_q + 8'd1;
        wait_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wait_s = mem_req;
                if (mem_req) begin
                    state_d = ST_BUSY;
                    stb_d   = 1'b1;
                    we_d    = mem_we;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    sel_d   = mem_be;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                wait_s = 1'b1;
                // An ack arriving in the timeout cycle still completes normally.
                if (bus.bus_ack) begin
                    state_d = ST_DONE;
                    stb_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = bus.bus_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (cnt_inc_s == TO_LIMIT) begin
                    state_d = ST_DONE;
                    stb_d   = 1'b0;
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    cnt_d   = cnt_inc_s;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                stb_d   = 1'b0;
            end
        endcase
    end

    // State and registered bus/result outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            sel_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_mem_wait = wait_s;
    assign mem_rdata     = rdata_q;
    assign bus_err       = err_q;
    assign bus.bus_stb   = stb_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_sel   = sel_q;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Scoreboard bench for dmem_wait_ctrl: expected completions are queued when
// a request is driven and compared when the DONE cycle appears.
module tb_dmem_wait_ctrl;
    localparam int TO = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        data_mem_wait;
    logic [31:0] mem_rdata;
    logic        bus_err;

    dmem_wait_ctrl_if bif ();

    dmem_wait_ctrl #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .data_mem_wait (data_mem_wait),
        .mem_rdata     (mem_rdata),
        .bus_err       (bus_err),
        .bus           (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] model_rdata;

    task automatic check_val(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One access; ack_at = BUSY cycle (1-based) carrying bus_ack, 0 = never.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input int ack_at, input logic [31:0] ack_data,
                             input logic b2b);
        exp_t e;
        int   n;
        logic done;
        if (!b2b) begin
            mem_req = 1'b0;
            @(negedge clk);
        end
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_be = be;
        if (ack_at > 0 && ack_at <= TO) begin
            e.lat = ack_at + 1; e.err = 1'b0;
            if (!we) model_rdata = ack_data;
        end else begin
            e.lat = TO + 1; e.err = 1'b1;
            model_rdata = 32'd0;
        end
        e.rdata = model_rdata;
        sb_q.push_back(e);
        if (b2b) @(negedge clk);
        #1;
        check_val("idle_wait", data_mem_wait, 1'b1);
        check_val("idle_stb", bif.bus_stb, 1'b0);
        check_val("idle_err", bus_err, 1'b0);
        n = 0;
        done = 1'b0;
        while (!done && n < 64) begin
            @(negedge clk);
            n++;
            if (data_mem_wait) begin
                check_val("busy_fields", {bif.bus_stb, bif.bus_we, bif.bus_addr, bif.bus_wdata, bif.bus_sel},
                          {1'b1, we, addr, wdata, be});
                check_val("busy_err", bus_err, 1'b0);
                bif.bus_ack   = (n == ack_at);
                bif.bus_rdata = (n == ack_at) ? ack_data : $urandom;
            end else begin
                done = 1'b1;
            end
        end
        bif.bus_ack = 1'b0;
        e = sb_q.pop_front();
        check_val("done_seen", done, 1'b1);
        check_val("latency", n, e.lat);
        check_val("rdata", mem_rdata, e.rdata);
        check_val("bus_err", bus_err, e.err);
        check_val("done_stb", bif.bus_stb, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_be = 4'd0;
        bif.bus_ack = 1'b0; bif.bus_rdata = 32'd0;
        model_rdata = 32'd0;
        #1;
        check_val("rst_state", {bif.bus_stb, bif.bus_we, bif.bus_addr, bif.bus_wdata, bif.bus_sel, bus_err},
                  70'd0);
        check_val("rst_rdata", mem_rdata, 32'd0);
        check_val("rst_wait", data_mem_wait, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_access(1'b0, 32'h0000_0100, 32'd0, 4'hF, 1, 32'hDEAD_BEEF, 1'b0);
        do_access(1'b1, 32'h0000_0040, 32'h1234_5678, 4'b0011, 5, 32'h0BAD_0BAD, 1'b0);
        do_access(1'b0, 32'h0000_0300, 32'd0, 4'hF, 0, 32'd0, 1'b0);
        do_access(1'b0, 32'h0000_0304, 32'd0, 4'hF, TO, 32'hCAFE_F00D, 1'b0);
        do_access(1'b1, 32'h0000_0308, 32'hAAAA_5555, 4'b1100, 3, 32'd0, 1'b0);

        // Stray ack while idle must not touch any state.
        mem_req = 1'b0;
        @(negedge clk);
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'h5555_5555;
        @(negedge clk);
        bif.bus_ack = 1'b0;
        check_val("stray_ack_rdata", mem_rdata, model_rdata);
        check_val("stray_ack_stb", bif.bus_stb, 1'b0);
        check_val("stray_ack_wait", data_mem_wait, 1'b0);
        check_val("stray_ack_err", bus_err, 1'b0);

        do_access(1'b0, 32'h0000_0200, 32'd0, 4'hF, 2, 32'h1111_1111, 1'b0);
        do_access(1'b0, 32'h0000_0204, 32'd0, 4'hF, 1, 32'h2222_2222, 1'b1);

        for (int i = 0; i < 8; i++) begin
            do_access(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                      4'($urandom_range(1, 15)), $urandom_range(0, TO + 2), $urandom,
                      1'($urandom_range(0, 1)));
        end

        // Reset in the middle of BUSY abandons the access.
        mem_req = 1'b0;
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0400; mem_be = 4'hF;
        @(negedge clk);
        check_val("pre_rst_stb", bif.bus_stb, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("async_rst_stb", bif.bus_stb, 1'b0);
        check_val("async_rst_rdata", mem_rdata, 32'd0);
        check_val("async_rst_wait_req", data_mem_wait, 1'b1);
        mem_req = 1'b0;
        #1;
        check_val("async_rst_wait_noreq", data_mem_wait, 1'b0);
        model_rdata = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("post_rst_quiet", {bif.bus_stb, bus_err, data_mem_wait}, 3'b000);
        end
        do_access(1'b0, 32'h0000_0500, 32'd0, 4'hF, 2, 32'h7777_8888, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
